// File: rtl/multicycle_sequencer_if.sv
// Handshake/control bundle between the multi-cycle sequencer and the rest of
// the RV32I core (instruction register, memories, register file, PC).
// The master modport is the sequencer side and drives every strobe; the slave
// modport is the core/memory side.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       Opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_req;
  logic             mem_read_en;
  logic             mem_write_en;
  logic             reg_write_en;
  logic             pc_write;
  logic [2:0]       state;
  logic             halted;
  logic             err_timeout;
  logic             err_illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  Opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, mem_read_en, mem_write_en,
           reg_write_en, pc_write, state, halted, err_timeout, err_illegal,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output Opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, mem_read_en, mem_write_en,
           reg_write_en, pc_write, state, halted, err_timeout, err_illegal,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core. Sequences one instruction at a
// time through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data
// memory under a bounded wait, and stops on HALT, illegal opcode or timeout.
// Optional feature macro: PERF_COUNTERS_EN enables the cycle/instret counters;
// without it both counter outputs are tied to zero.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  // Wide enough to hold MEM_WAIT_MAX-1 with headroom; with MEM_WAIT_MAX=0 the
  // counter is free-running and never compared.
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_WAIT_MAX > 0) ? WAIT_W'(MEM_WAIT_MAX - 1) : '0;

  state_t            state_q, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              timeout_hit;
  logic              set_timeout, set_illegal;
  logic              err_timeout_q, err_illegal_q;

  logic is_lw, is_sw, is_br, is_halt, is_legal;

  logic imem_req_c, ir_write_c, dmem_req_c, mem_read_c, mem_write_c;
  logic reg_write_c, pc_write_c, halted_c;

  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  // Opcode classification shared by DECODE routing and EXEC/MEM qualification.
  always_comb begin
    is_lw    = (bus.Opcode == OP_LW);
    is_sw    = (bus.Opcode == OP_SW);
    is_br    = (bus.Opcode == OP_BR);
    is_halt  = (bus.Opcode == OP_HALT);
    is_legal = 1'b0;
    case (bus.Opcode)
      OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                                             is_legal = 1'b0;
    endcase
  end

  // The timeout fires in the MEM_WAIT_MAX-th cycle of a wait state when ready
  // is still low; ready in that same cycle wins because it is tested first.
  assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_next;
  end

  // Next-state logic and Moore outputs qualified by Opcode/ready.
  always_comb begin
    state_next  = state_q;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    dmem_req_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    pc_write_c  = 1'b0;
    halted_c    = 1'b0;
    wait_inc    = 1'b0;
    set_timeout = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          state_next  = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_next = S_HALT;
        end else if (is_legal) begin
          state_next = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          state_next  = S_ERR;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else if (is_br) begin
          pc_write_c = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c  = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (bus.dmem_ready) begin
          if (is_lw) begin
            state_next = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_next = S_FETCH;
          end
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          state_next  = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_next  = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Wait counter: restarts on every state change, so each entry to FETCH/MEM
  // begins counting from zero.
  always_ff @(posedge clk) begin
    if (reset)                     wait_cnt <= '0;
    else if (state_next != state_q) wait_cnt <= '0;
    else if (wait_inc)             wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      if (set_timeout) err_timeout_q <= 1'b1;
      if (set_illegal) err_illegal_q <= 1'b1;
    end
  end

`ifdef PERF_COUNTERS_EN
  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_ERR) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (pc_write_c) instret_cnt_q <= instret_cnt_q + 1'b1;
    end
  end
`else
  assign cycle_cnt_q   = '0;
  assign instret_cnt_q = '0;
`endif

  // Output stage: everything forced low while reset is held, which also
  // suppresses the retire strobe of an instruction aborted by reset.
  assign bus.imem_req     = imem_req_c  & ~reset;
  assign bus.ir_write     = ir_write_c  & ~reset;
  assign bus.dmem_req     = dmem_req_c  & ~reset;
  assign bus.mem_read_en  = mem_read_c  & ~reset;
  assign bus.mem_write_en = mem_write_c & ~reset;
  assign bus.reg_write_en = reg_write_c & ~reset;
  assign bus.pc_write     = pc_write_c  & ~reset;
  assign bus.halted       = halted_c    & ~reset;
  assign bus.err_timeout  = err_timeout_q & ~reset;
  assign bus.err_illegal  = err_illegal_q & ~reset;
  assign bus.state        = reset ? 3'd0 : state_q;
  assign bus.cycle_cnt    = reset ? '0 : cycle_cnt_q;
  assign bus.instret_cnt  = reset ? '0 : instret_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle table of
// {reset, opcode, readies, expected state, expected strobes} followed by a
// hand-written counter/reset-abort sequence.
module tb_multicycle_sequencer;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] HLT  = 7'b1111111;
  localparam logic [6:0] ILL  = 7'b0000000;

  // Strobe vector order:
  // {imem_req, ir_write, dmem_req, mem_read_en, mem_write_en,
  //  reg_write_en, pc_write, halted, err_timeout, err_illegal}
  localparam logic [9:0] O_0   = 10'b0000000000;
  localparam logic [9:0] O_F   = 10'b1000000000;
  localparam logic [9:0] O_FR  = 10'b1100000000;
  localparam logic [9:0] O_WB  = 10'b0000011000;
  localparam logic [9:0] O_LWM = 10'b0011000000;
  localparam logic [9:0] O_SWM = 10'b0010100000;
  localparam logic [9:0] O_SWD = 10'b0010101000;
  localparam logic [9:0] O_BR  = 10'b0000001000;
  localparam logic [9:0] O_HLT = 10'b0000000100;
  localparam logic [9:0] O_ET  = 10'b0000000010;
  localparam logic [9:0] O_EI  = 10'b0000000001;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       ir;
    logic       dr;
    logic [2:0] st;
    logic [9:0] o;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  vec_t vq[$];

  multicycle_sequencer_if #(.CNT_W(32)) bus ();

  multicycle_sequencer #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [9:0] outs;
  assign outs = {bus.imem_req, bus.ir_write, bus.dmem_req, bus.mem_read_en,
                 bus.mem_write_en, bus.reg_write_en, bus.pc_write, bus.halted,
                 bus.err_timeout, bus.err_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic [6:0] op,
                              input logic ir, input logic dr,
                              input logic [2:0] st, input logic [9:0] o);
    vec_t v;
    v.rst = rst; v.op = op; v.ir = ir; v.dr = dr; v.st = st; v.o = o;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] op,
                       input logic ir, input logic dr);
    reset          = rst;
    bus.Opcode     = op;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt_cyc;
  int exp_cnt_ret;
  int pcw_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b1, ADD, 1'b0, 1'b0);

    // Reset state, then ADD with zero-wait memory.
    add(1, ADD, 1, 1, 3'd0, O_0);
    add(0, ADD, 1, 1, 3'd0, O_FR);
    add(0, ADD, 1, 1, 3'd1, O_0);
    add(0, ADD, 1, 1, 3'd2, O_0);
    add(0, ADD, 1, 1, 3'd4, O_WB);
    // LW with dmem_ready low for three MEM cycles.
    add(0, LW, 1, 0, 3'd0, O_FR);
    add(0, LW, 1, 0, 3'd1, O_0);
    add(0, LW, 1, 0, 3'd2, O_0);
    add(0, LW, 1, 0, 3'd3, O_LWM);
    add(0, LW, 1, 0, 3'd3, O_LWM);
    add(0, LW, 1, 0, 3'd3, O_LWM);
    add(0, LW, 1, 1, 3'd3, O_LWM);
    add(0, LW, 1, 1, 3'd4, O_WB);
    // SW then BEQ.
    add(0, SW, 1, 1, 3'd0, O_FR);
    add(0, SW, 1, 1, 3'd1, O_0);
    add(0, SW, 1, 1, 3'd2, O_0);
    add(0, SW, 1, 1, 3'd3, O_SWD);
    add(0, BEQ, 1, 1, 3'd0, O_FR);
    add(0, BEQ, 1, 1, 3'd1, O_0);
    add(0, BEQ, 1, 1, 3'd2, O_BR);
    // Fetch ready arriving in the last allowed cycle (4) is accepted.
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 1, 1, 3'd0, O_FR);
    add(0, ADD, 1, 1, 3'd1, O_0);
    add(0, ADD, 1, 1, 3'd2, O_0);
    add(0, ADD, 1, 1, 3'd4, O_WB);
    // Fetch timeout: four waiting cycles, then ERR; late ready is ignored.
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd0, O_F);
    add(0, ADD, 0, 1, 3'd6, O_ET);
    add(0, ADD, 1, 1, 3'd6, O_ET);
    add(1, ADD, 1, 1, 3'd0, O_0);
    // HALT held for 20 cycles, then reset.
    add(0, HLT, 1, 1, 3'd0, O_FR);
    add(0, HLT, 1, 1, 3'd1, O_0);
    for (int i = 0; i < 20; i++) add(0, HLT, 1, 1, 3'd5, O_HLT);
    add(1, HLT, 1, 1, 3'd0, O_0);
    // Illegal opcode, then reset.
    add(0, ILL, 1, 1, 3'd0, O_FR);
    add(0, ILL, 1, 1, 3'd1, O_0);
    add(0, ILL, 1, 1, 3'd6, O_EI);
    add(0, ILL, 1, 1, 3'd6, O_EI);
    add(1, ILL, 1, 1, 3'd0, O_0);
    // JAL goes through WB.
    add(0, JAL, 1, 1, 3'd0, O_FR);
    add(0, JAL, 1, 1, 3'd1, O_0);
    add(0, JAL, 1, 1, 3'd2, O_0);
    add(0, JAL, 1, 1, 3'd4, O_WB);
    // SW data timeout: strobes drop at ERR entry.
    add(0, SW, 1, 0, 3'd0, O_FR);
    add(0, SW, 1, 0, 3'd1, O_0);
    add(0, SW, 1, 0, 3'd2, O_0);
    add(0, SW, 1, 0, 3'd3, O_SWM);
    add(0, SW, 1, 0, 3'd3, O_SWM);
    add(0, SW, 1, 0, 3'd3, O_SWM);
    add(0, SW, 1, 0, 3'd3, O_SWM);
    add(0, SW, 1, 0, 3'd6, O_ET);
    add(1, SW, 1, 0, 3'd0, O_0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].op, vq[i].ir, vq[i].dr);
      @(negedge clk);
      chk("state", i, 32'(bus.state), 32'(vq[i].st));
      chk("strobes", i, 32'(outs), 32'(vq[i].o));
      next_cycle();
    end

    // Ten back-to-back ADDs from reset, counting retire strobes.
`ifdef PERF_COUNTERS_EN
    exp_cnt_cyc = 40;
    exp_cnt_ret = 10;
`else
    exp_cnt_cyc = 0;
    exp_cnt_ret = 0;
`endif
    drive(1'b1, ADD, 1'b1, 1'b1);
    @(negedge clk);
    chk("cycle_cnt_rst", 0, bus.cycle_cnt, 32'd0);
    chk("instret_cnt_rst", 0, bus.instret_cnt, 32'd0);
    next_cycle();
    pcw_seen = 0;
    drive(1'b0, ADD, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pc_write) pcw_seen++;
      next_cycle();
    end
    @(negedge clk);
    chk("pc_write_count", 0, 32'(pcw_seen), 32'd10);
    chk("cycle_cnt", 0, bus.cycle_cnt, 32'(exp_cnt_cyc));
    chk("instret_cnt", 0, bus.instret_cnt, 32'(exp_cnt_ret));
    chk("state_after_10", 0, 32'(bus.state), 32'd0);
    next_cycle();
    // DECODE, then reset asserted while in EXEC.
    next_cycle();
    drive(1'b1, BEQ, 1'b1, 1'b1);
    @(negedge clk);
    chk("abort_strobes", 0, 32'(outs), 32'(O_0));
    chk("abort_state", 0, 32'(bus.state), 32'd0);
    chk("abort_cycle_cnt", 0, bus.cycle_cnt, 32'd0);
    chk("abort_instret", 0, bus.instret_cnt, 32'd0);
    next_cycle();
    drive(1'b0, BEQ, 1'b1, 1'b1);
    @(negedge clk);
    chk("resume_state", 0, 32'(bus.state), 32'd0);
    chk("resume_strobes", 0, 32'(outs), 32'(O_FR));
    chk("resume_instret", 0, bus.instret_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
